clear_seq_ctrl: RTL and testbench

//  Single-clock sequencer that drives one soft clear through the four phases of
//  cdc_clear_sync_pkg::clear_seq_phase_e: IDLE, ISOLATE, CLEAR, POST_CLEAR.

---
 rtl/cdc_clear_sync_pkg.sv | 22 ++
 rtl/clear_seq_ctrl_counter.sv | 35 +++
 rtl/clear_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_clear_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_clear_sync_pkg.sv
// Shared types for the CDC clear path: the clear sequencing phases and
// the minimum legal cycle count for any sequencer phase.
package cdc_clear_sync_pkg;

  typedef enum logic [1:0] {
    CLEAR_PHASE_IDLE       = 2'd0,
    CLEAR_PHASE_ISOLATE    = 2'd1,
    CLEAR_PHASE_CLEAR      = 2'd2,
    CLEAR_PHASE_POST_CLEAR = 2'd3
  } clear_seq_phase_e;

  localparam int unsigned CLEAR_SEQ_MIN_CYCLES = 1;

  function automatic int unsigned clear_seq_max3(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clear_seq_ctrl_counter.sv
// Loadable down counter that saturates at zero; used for the phase and
// isolate-timeout counts of the clear sequencer.
module clear_seq_ctrl_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clear_seq_ctrl.sv
// Soft-clear sequencer: IDLE -> ISOLATE -> CLEAR -> POST_CLEAR, with request
// coalescing. Define CLEAR_SEQ_TIMEOUT_EN to bound the isolate handshake wait.
module clear_seq_ctrl
  import cdc_clear_sync_pkg::*;
#(
  parameter int unsigned ClearCycles     = 4,
  parameter int unsigned PostClearCycles = 2,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_req_i,
  input  logic       isolated_i,
  output logic       isolate_o,
  output logic       clear_o,
  output logic [1:0] phase_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
);

  if (ClearCycles < CLEAR_SEQ_MIN_CYCLES) begin : g_bad_clear_cycles
    $error("clear_seq_ctrl: ClearCycles must be >= 1");
  end
  if (PostClearCycles < CLEAR_SEQ_MIN_CYCLES) begin : g_bad_post_cycles
    $error("clear_seq_ctrl: PostClearCycles must be >= 1");
  end
  if (TimeoutCycles < CLEAR_SEQ_MIN_CYCLES) begin : g_bad_timeout_cycles
    $error("clear_seq_ctrl: TimeoutCycles must be >= 1");
  end

  localparam int unsigned CntW =
    $clog2(clear_seq_max3(ClearCycles, PostClearCycles, TimeoutCycles)) + 1;
  localparam logic [CntW-1:0] ClearLoad = CntW'(ClearCycles - 1);
  localparam logic [CntW-1:0] PostLoad  = CntW'(PostClearCycles - 1);
`ifdef CLEAR_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 1);
`endif

  clear_seq_phase_e phase_d, phase_q;
  logic             pending_d, pending_q;
  logic             done_d, done_q;
  logic             timeout_d, timeout_q;
  logic             cnt_load;
  logic [CntW-1:0]  cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;

  clear_seq_ctrl_counter #(
    .Width (CntW)
  ) u_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    phase_d      = phase_q;
    pending_d    = pending_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    unique case (phase_q)
      CLEAR_PHASE_IDLE: begin
        if (clear_req_i) begin
          phase_d = CLEAR_PHASE_ISOLATE;
`ifdef CLEAR_SEQ_TIMEOUT_EN
          cnt_load     = 1'b1;
          cnt_load_val = TimeoutLoad;
`endif
        end
      end
      CLEAR_PHASE_ISOLATE: begin
        if (clear_req_i) pending_d = 1'b1;
        if (isolated_i) begin
          phase_d      = CLEAR_PHASE_CLEAR;
          cnt_load     = 1'b1;
          cnt_load_val = ClearLoad;
`ifdef CLEAR_SEQ_TIMEOUT_EN
        end else if (cnt_zero) begin
          // Handshake never came: force the clear anyway and flag it.
          phase_d      = CLEAR_PHASE_CLEAR;
          timeout_d    = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = ClearLoad;
        end else begin
          cnt_en = 1'b1;
`endif
        end
      end
      CLEAR_PHASE_CLEAR: begin
        if (clear_req_i) pending_d = 1'b1;
        if (cnt_zero) begin
          phase_d      = CLEAR_PHASE_POST_CLEAR;
          cnt_load     = 1'b1;
          cnt_load_val = PostLoad;
        end else begin
          cnt_en = 1'b1;
        end
      end
      CLEAR_PHASE_POST_CLEAR: begin
        if (clear_req_i) pending_d = 1'b1;
        if (cnt_zero) begin
          done_d = 1'b1;
          // A request on this last cycle still earns a follow-on sequence.
          if (pending_q || clear_req_i) begin
            phase_d   = CLEAR_PHASE_ISOLATE;
            pending_d = 1'b0;
`ifdef CLEAR_SEQ_TIMEOUT_EN
            cnt_load     = 1'b1;
            cnt_load_val = TimeoutLoad;
`endif
          end else begin
            phase_d = CLEAR_PHASE_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: phase_d = CLEAR_PHASE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= CLEAR_PHASE_IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign phase_o   = phase_q;
  assign busy_o    = (phase_q != CLEAR_PHASE_IDLE);
  assign isolate_o = (phase_q != CLEAR_PHASE_IDLE);
  assign clear_o   = (phase_q == CLEAR_PHASE_CLEAR);
  assign done_o    = done_q;
`ifdef CLEAR_SEQ_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_clear_seq_ctrl.sv
// Bench for clear_seq_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a phase/elapsed-time reference model.
module tb_clear_seq_ctrl;
  import cdc_clear_sync_pkg::*;

  localparam int unsigned CLR_N  = 4;
  localparam int unsigned POST_N = 2;
  localparam int unsigned TMO_N  = 8;
`ifdef CLEAR_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [1:0] P_IDLE = CLEAR_PHASE_IDLE;
  localparam logic [1:0] P_ISO  = CLEAR_PHASE_ISOLATE;
  localparam logic [1:0] P_CLR  = CLEAR_PHASE_CLEAR;
  localparam logic [1:0] P_POST = CLEAR_PHASE_POST_CLEAR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_req = 1'b0;
  logic isolated = 1'b0;
  logic isolate_o, clear_o, busy_o, done_o, timeout_o;
  logic [1:0] phase_o;

  always #5 clk = ~clk;

  clear_seq_ctrl #(
    .ClearCycles     (CLR_N),
    .PostClearCycles (POST_N),
    .TimeoutCycles   (TMO_N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_req_i (clear_req),
    .isolated_i  (isolated),
    .isolate_o   (isolate_o),
    .clear_o     (clear_o),
    .phase_o     (phase_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the phase and how many cycles have elapsed in it.
  logic [1:0] m_phase = 2'd0;
  int         m_el = 0;
  bit         m_pend = 1'b0, m_done = 1'b0, m_to = 1'b0, m_valid = 1'b0, m_rst = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_rst = rst;
    if (rst) begin
      m_valid = 1'b1;
      m_phase = P_IDLE;
      m_el = 0; m_pend = 1'b0; m_done = 1'b0; m_to = 1'b0;
    end else if (m_valid) begin
      m_done = 1'b0;
      m_to   = 1'b0;
      case (m_phase)
        P_IDLE: if (clear_req) begin m_phase = P_ISO; m_el = 0; end
        P_ISO: begin
          if (clear_req) m_pend = 1'b1;
          if (isolated) begin
            m_phase = P_CLR; m_el = 0;
          end else if (TMO_EN && (m_el + 1 == int'(TMO_N))) begin
            m_phase = P_CLR; m_el = 0; m_to = 1'b1;
          end else m_el++;
        end
        P_CLR: begin
          if (clear_req) m_pend = 1'b1;
          if (m_el + 1 == int'(CLR_N)) begin m_phase = P_POST; m_el = 0; end
          else m_el++;
        end
        default: begin
          if (m_el + 1 == int'(POST_N)) begin
            m_done = 1'b1;
            m_el = 0;
            if (m_pend || clear_req) begin m_phase = P_ISO; m_pend = 1'b0; end
            else m_phase = P_IDLE;
          end else begin
            if (clear_req) m_pend = 1'b1;
            m_el++;
          end
        end
      endcase
    end
  end

  function automatic bit legal_step(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 1'b1;
    case (a)
      P_IDLE:  return b == P_ISO;
      P_ISO:   return b == P_CLR;
      P_CLR:   return b == P_POST;
      P_POST:  return (b == P_IDLE) || (b == P_ISO);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int clear_cnt, post_cnt, done_cnt, done_cyc, to_cnt, iso_cnt, iso_entries, idle_between;
  logic [1:0] prev_phase = 2'd0;

  task automatic clear_stats();
    clear_cnt = 0; post_cnt = 0; done_cnt = 0; done_cyc = 0;
    to_cnt = 0; iso_cnt = 0; iso_entries = 0; idle_between = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("phase", 32'(phase_o), 32'(m_phase));
      check("isolate", 32'(isolate_o), 32'(m_phase != P_IDLE));
      check("clear", 32'(clear_o), 32'(m_phase == P_CLR));
      check("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
      check("done", 32'(done_o), 32'(m_done));
      check("timeout", 32'(timeout_o), 32'(m_to));
      check("clear_implies_isolate", 32'(!clear_o || isolate_o), 32'd1);
      check("busy_vs_phase", 32'(busy_o), 32'(phase_o != P_IDLE));
      if (!m_rst) check("legal_transition", 32'(legal_step(prev_phase, phase_o)), 32'd1);
      if (clear_o) clear_cnt++;
      if (phase_o == P_POST) post_cnt++;
      if (timeout_o) to_cnt++;
      if (phase_o == P_ISO) iso_cnt++;
      if (phase_o == P_ISO && prev_phase != P_ISO) iso_entries++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (phase_o == P_IDLE && done_cnt == 1) idle_between++;
    end
    prev_phase = phase_o;
  end

  // ---------------- driver tasks ----------------
  int req_cyc = 0;

  task automatic pulse_req();
    @(negedge clk);
    clear_req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int limit, input string name);
    int n = 0;
    while (phase_o !== p && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(phase_o), 32'(p));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_stats();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_phase", 32'(phase_o), 32'd0);
    check("reset_outputs", 32'({isolate_o, clear_o, busy_o, done_o, timeout_o}), 32'd0);
    rst = 1'b0;

    // Basic sequence: isolation granted two cycles after the request.
    clear_stats();
    @(negedge clk);
    clear_req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    isolated = 1'b1;
    wait_phase(P_IDLE, 40, "basic_idle");
    check("basic_clear_len", 32'(clear_cnt), 32'd4);
    check("basic_post_len", 32'(post_cnt), 32'd2);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_done_latency", 32'(done_cyc - req_cyc), 32'd9);

    // Three requests while busy coalesce into one back-to-back sequence.
    clear_stats();
    pulse_req();
    wait_phase(P_CLR, 20, "coalesce_enter_clear");
    repeat (3) pulse_req();
    repeat (30) begin
      if (done_cnt < 2 || phase_o != P_IDLE) @(negedge clk);
    end
    check("coalesce_done_cnt", 32'(done_cnt), 32'd2);
    check("coalesce_seq_cnt", 32'(iso_entries), 32'd2);
    check("coalesce_no_idle_gap", 32'(idle_between), 32'd0);
    check("coalesce_clear_len", 32'(clear_cnt), 32'd8);

    // Losing isolation during CLEAR must not disturb the sequence.
    clear_stats();
    pulse_req();
    wait_phase(P_CLR, 20, "drop_enter_clear");
    @(negedge clk);
    isolated = 1'b0;
    wait_phase(P_IDLE, 40, "drop_idle");
    check("drop_clear_len", 32'(clear_cnt), 32'd4);
    check("drop_post_len", 32'(post_cnt), 32'd2);
    check("drop_done_cnt", 32'(done_cnt), 32'd1);

    // Reset held three cycles in the middle of CLEAR.
    isolated = 1'b1;
    pulse_req();
    wait_phase(P_CLR, 20, "rst_enter_clear");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_phase", 32'(phase_o), 32'd0);
    check("midrst_outputs", 32'({isolate_o, clear_o, busy_o, done_o, timeout_o}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Isolation never granted.
    clear_stats();
    isolated = 1'b0;
    pulse_req();
`ifdef CLEAR_SEQ_TIMEOUT_EN
    wait_phase(P_CLR, 40, "timeout_enter_clear");
    check("timeout_iso_len", 32'(iso_cnt), 32'd8);
    check("timeout_pulse_cnt", 32'(to_cnt), 32'd1);
    isolated = 1'b1;
    wait_phase(P_IDLE, 40, "timeout_idle");
    check("timeout_pulse_once", 32'(to_cnt), 32'd1);
`else
    repeat (120) @(negedge clk);
    check("hold_iso_phase", 32'(phase_o), 32'(P_ISO));
    check("hold_iso_long", 32'(iso_cnt >= 100), 32'd1);
    check("hold_no_timeout", 32'(to_cnt), 32'd0);
    isolated = 1'b1;
    wait_phase(P_IDLE, 40, "hold_idle");
`endif

    // Random traffic, checked by the model every cycle.
    repeat (3000) begin
      @(negedge clk);
      clear_req = ($urandom_range(0, 7) == 0);
      isolated  = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_req = 1'b0;
    isolated = 1'b1;
    wait_phase(P_IDLE, 200, "random_drain_idle");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
